// File: rtl/avg_pkg.sv
// avg_pkg: opcodes, command kinds, intensity decode and command record shared by the AVG fetch/decode slice
package avg_pkg;
  typedef enum logic [2:0] {
    OP_VCTR, OP_HALT, OP_SVEC, OP_STSC, OP_CNTR, OP_JSR, OP_RTS, OP_JMP
  } avg_op_e;
  typedef enum logic [1:0] {CK_VEC, CK_STAT, CK_SCAL, CK_CNTR} cmd_kind_e;
  localparam logic [2:0] ZC_BLANK = 3'd0;
  localparam logic [2:0] ZC_ZREG  = 3'd1;
  typedef struct packed {
    cmd_kind_e  kind;
    logic [3:0] z;
    logic       use_zreg;
    logic       blank;
    logic [2:0] color;
    logic [7:0] lin;
    logic [2:0] bin;
  } avg_cmd_t;
  function automatic logic is_draw(avg_op_e op);
    return op inside {OP_VCTR, OP_SVEC, OP_STSC, OP_CNTR};
  endfunction
  function automatic avg_cmd_t zc_cmd(logic [2:0] zc);
    avg_cmd_t c;
    c = '0;
    c.kind = CK_VEC;
    c.blank = zc == ZC_BLANK;
    c.use_zreg = zc == ZC_ZREG;
    c.z = (zc == ZC_BLANK || zc == ZC_ZREG) ? 4'd0 : {zc, 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/avg_ret_stack.sv
// avg_ret_stack: circular return-address stack; pointer wraps, occupancy count saturates for full/empty
module avg_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0] cnt_q, cnt_d;
  assign ptr_inc  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec  = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  assign pop_data = mem_q[ptr_dec];
  assign full     = cnt_q == CW'(DEPTH);
  assign empty    = cnt_q == '0;
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d = ptr_inc;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
    end else if (pop) begin
      ptr_d = ptr_dec;
      cnt_d = empty ? cnt_q : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/avg_fetch_decode.sv
// avg_fetch_decode: AVG vector-RAM fetch, decode and local flow control feeding the vector engine
// AVG_STACK_CHECK_EN: halt with sticky err on return-stack overflow/underflow instead of wrapping
module avg_fetch_decode
  import avg_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int COORD_W     = 13,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               abort,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_kind,
  output logic [COORD_W-1:0] cmd_dx,
  output logic [COORD_W-1:0] cmd_dy,
  output logic [3:0]         cmd_z,
  output logic               cmd_use_zreg,
  output logic               cmd_blank,
  output logic [2:0]         cmd_color,
  output logic [7:0]         cmd_lin,
  output logic [2:0]         cmd_bin,
  output logic               busy,
  output logic               halted,
  output logic               err
);
`ifdef AVG_STACK_CHECK_EN
  localparam logic STACK_CHECK = 1'b1;
`else
  localparam logic STACK_CHECK = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_CAP0, S_RD1, S_CAP1, S_EXEC, S_HALTED} state_e;
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, target, pop_data;
  logic [15:0]         w0_q, w0_d, w0s;
  avg_cmd_t            cmd_q, cmd_d, dec;
  logic [COORD_W-1:0]  dx_q, dx_d, dy_q, dy_d;
  logic                err_q, err_d, push, pop, clear, full, empty, vec;
  avg_op_e             op_s, op_q;
  logic [12:0]         dx13, dy13;
  logic [2:0]          zc;
  avg_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop),
    .push_data(pc_q), .pop_data(pop_data), .full(full), .empty(empty)
  );
  // In CAP1 the first word is already latched; the bus carries the second word
  assign w0s    = (state_q == S_CAP1) ? w0_q : mem_rdata;
  assign op_s   = avg_op_e'(w0s[15:13]);
  assign op_q   = avg_op_e'(w0_q[15:13]);
  assign target = ADDR_W'(w0_q[12:0]);
  assign vec    = op_s inside {OP_VCTR, OP_SVEC};
  assign dy13   = (op_s == OP_SVEC) ? {{7{w0s[12]}}, w0s[12:8], 1'b0} : w0s[12:0];
  assign dx13   = (op_s == OP_SVEC) ? {{7{w0s[4]}}, w0s[4:0], 1'b0} : mem_rdata[12:0];
  assign zc     = (op_s == OP_SVEC) ? w0s[7:5] : mem_rdata[15:13];
  always_comb begin
    dec = zc_cmd(zc);
    if (op_s == OP_STSC) begin
      dec = '0;
      dec.kind = w0s[12] ? CK_SCAL : CK_STAT;
      dec.z = w0s[12] ? 4'd0 : w0s[7:4];
      dec.color = w0s[12] ? 3'd0 : w0s[2:0];
      dec.bin = w0s[12] ? w0s[10:8] : 3'd0;
      dec.lin = w0s[12] ? w0s[7:0] : 8'd0;
    end else if (op_s == OP_CNTR) begin
      dec = '0;
      dec.kind = CK_CNTR;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    w0_d = w0_q;
    cmd_d = cmd_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    push = 1'b0;
    pop = 1'b0;
    clear = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        state_d = go ? S_RD0 : state_q;
        pc_d = go ? '0 : pc_q;
      end
      S_RD0: state_d = S_CAP0;
      S_CAP0: begin
        w0_d = mem_rdata;
        pc_d = pc_q + 1'b1;
        state_d = (op_s == OP_VCTR) ? S_RD1 : S_EXEC;
      end
      S_RD1: state_d = S_CAP1;
      S_CAP1: begin
        pc_d = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_RD0;
        if (op_q == OP_HALT) state_d = S_HALTED;
        else if (op_q == OP_JMP) pc_d = target;
        else if (op_q == OP_JSR && STACK_CHECK && full) begin
          err_d = 1'b1;
          state_d = S_HALTED;
        end else if (op_q == OP_JSR) begin
          push = 1'b1;
          pc_d = target;
        end else if (op_q == OP_RTS && STACK_CHECK && empty) begin
          err_d = 1'b1;
          state_d = S_HALTED;
        end else if (op_q == OP_RTS) begin
          pop = 1'b1;
          pc_d = pop_data;
        end else if (!cmd_ready) state_d = S_EXEC;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_CAP0 || state_q == S_CAP1) begin
      cmd_d = dec;
      dx_d = vec ? COORD_W'($signed(dx13)) : '0;
      dy_d = vec ? COORD_W'($signed(dy13)) : '0;
    end
    if (abort) begin
      state_d = S_IDLE;
      pc_d = '0;
      cmd_d = '0;
      dx_d = '0;
      dy_d = '0;
      err_d = 1'b0;
      clear = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      w0_q <= '0;
      cmd_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      w0_q <= w0_d;
      cmd_q <= cmd_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
    end
  end
  assign mem_rd       = state_q == S_RD0 || state_q == S_RD1;
  assign mem_addr     = pc_q;
  assign cmd_valid    = state_q == S_EXEC && is_draw(op_q);
  assign cmd_kind     = cmd_q.kind;
  assign cmd_dx       = dx_q;
  assign cmd_dy       = dy_q;
  assign cmd_z        = cmd_q.z;
  assign cmd_use_zreg = cmd_q.use_zreg;
  assign cmd_blank    = cmd_q.blank;
  assign cmd_color    = cmd_q.color;
  assign cmd_lin      = cmd_q.lin;
  assign cmd_bin      = cmd_q.bin;
  assign busy         = !(state_q == S_IDLE || state_q == S_HALTED);
  assign halted       = state_q == S_HALTED;
  assign err          = err_q;
endmodule

// File: tb/tb_avg_fetch_decode.sv
// tb_avg_fetch_decode: scoreboard bench for avg_fetch_decode with a 1-cycle-latency vector RAM
module tb_avg_fetch_decode;
  localparam int AW = 13;
  localparam int CW = 13;
  localparam int D  = 4;
  localparam logic [15:0] HALT = 16'h2000;
  localparam logic [15:0] RTS  = 16'hC000;
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, abort = 1'b0, cmd_ready = 1'b1;
  logic mem_rd, cmd_valid, cmd_use_zreg, cmd_blank, busy, halted, err;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [1:0] cmd_kind;
  logic [CW-1:0] cmd_dx, cmd_dy;
  logic [3:0] cmd_z;
  logic [2:0] cmd_color, cmd_bin;
  logic [7:0] cmd_lin;
  logic [15:0] ram [2**AW];
  logic [47:0] exp_q [$];
  logic [AW-1:0] addr_q [$];
  bit addr_on = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= ram[mem_addr];

  avg_fetch_decode #(.ADDR_W(AW), .COORD_W(CW), .STACK_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_z(cmd_z), .cmd_use_zreg(cmd_use_zreg),
    .cmd_blank(cmd_blank), .cmd_color(cmd_color), .cmd_lin(cmd_lin), .cmd_bin(cmd_bin),
    .busy(busy), .halted(halted), .err(err)
  );

  function automatic logic [47:0] cmdv(logic [1:0] k, logic [12:0] dx, logic [12:0] dy,
      logic [3:0] z, logic uz, logic bl, logic [2:0] col, logic [7:0] lin, logic [2:0] bin);
    return {k, dx, dy, z, uz, bl, col, lin, bin};
  endfunction

  function automatic logic [12:0] lvl(int k);
    return 13'(k * 16);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      chk("cmd_pending", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("cmd", cmdv(cmd_kind, cmd_dx, cmd_dy, cmd_z, cmd_use_zreg, cmd_blank,
                        cmd_color, cmd_lin, cmd_bin), exp_q[0]);
        if (cmd_ready) void'(exp_q.pop_front());
      end
    end
    if (addr_on && mem_rd) begin
      chk("fetch_pending", 64'(addr_q.size() > 0), 1);
      if (addr_q.size() > 0) begin
        chk("fetch_addr", mem_addr, addr_q[0]);
        void'(addr_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram;
    for (int i = 0; i < 2**AW; i++) ram[i] = HALT;
  endtask

  task automatic pulse_go;
    go = 1'b1;
    tick;
    go = 1'b0;
  endtask

  task automatic go_lat(input string tag, input int exp_cyc);
    int c;
    pulse_go;
    chk("go_rd0", {mem_rd, mem_addr}, {1'b1, 13'd0});
    c = 1;
    while (!cmd_valid && c < 20) begin
      tick;
      c++;
    end
    chk(tag, c, exp_cyc);
  endtask

  task automatic wait_halt(input string tag, input bit rnd);
    int n;
    n = 0;
    while (!halted && n < 2000) begin
      if (rnd) cmd_ready = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    cmd_ready = 1'b1;
    chk(tag, halted, 1);
  endtask

  task automatic drain(input string tag);
    chk(tag, 64'(exp_q.size() + addr_q.size()), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    clear_ram;
    repeat (3) tick;
    chk("reset", {busy, halted, err, cmd_valid, mem_rd, mem_addr}, 0);
    rst_n = 1'b1;
    tick;
    // T1: blanked zero-length SVEC then HALT
    ram[0] = 16'h4000;
    exp_q.push_back(cmdv(2'd0, 13'd0, 13'd0, 4'd0, 1'b0, 1'b1, 3'd0, 8'd0, 3'd0));
    go_lat("t1_lat", 3);
    wait_halt("t1_halt", 0);
    chk("t1_busy", busy, 0);
    drain("t1_drain");
    // T2: long vector latency and sign extension
    clear_ram;
    ram[0] = 16'h1FFF;
    ram[1] = 16'hE001;
    exp_q.push_back(cmdv(2'd0, 13'd1, 13'h1FFF, 4'hE, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0));
    go_lat("t2_lat", 5);
    wait_halt("t2_halt", 0);
    drain("t2_drain");
    // T3: backpressure holds STAT stable without refetch
    clear_ram;
    ram[0] = 16'h6073;
    exp_q.push_back(cmdv(2'd1, 13'd0, 13'd0, 4'd7, 1'b0, 1'b0, 3'd3, 8'd0, 3'd0));
    cmd_ready = 1'b0;
    go_lat("t3_lat", 3);
    repeat (10) tick;
    chk("t3_hold", {mem_rd, busy, cmd_valid, mem_addr}, {1'b0, 1'b1, 1'b1, 13'd1});
    cmd_ready = 1'b1;
    wait_halt("t3_halt", 0);
    drain("t3_drain");
    // T4a: single JSR/RTS returns to the next word
    clear_ram;
    ram[0] = 16'hA010;
    ram[16] = RTS;
    ram[1] = 16'h6011;
    addr_q = '{13'd0, 13'd16, 13'd1, 13'd2};
    exp_q.push_back(cmdv(2'd1, 13'd0, 13'd0, 4'd1, 1'b0, 1'b0, 3'd1, 8'd0, 3'd0));
    addr_on = 1'b1;
    pulse_go;
    wait_halt("t4a_halt", 0);
    chk("t4a_err", err, 0);
    drain("t4a_drain");
    // T4b: nested calls to full depth unwind in order
    clear_ram;
    for (int k = 0; k < D; k++) ram[lvl(k)] = 16'hA000 | 16'(lvl(k + 1));
    ram[lvl(D)] = 16'h60F2;
    for (int k = 1; k <= D; k++) ram[lvl(k) + 1] = RTS;
    for (int k = 0; k <= D; k++) addr_q.push_back(lvl(k));
    addr_q.push_back(lvl(D) + 13'd1);
    for (int k = D - 1; k >= 1; k--) addr_q.push_back(lvl(k) + 13'd1);
    addr_q.push_back(13'd1);
    exp_q.push_back(cmdv(2'd1, 13'd0, 13'd0, 4'hF, 1'b0, 1'b0, 3'd2, 8'd0, 3'd0));
    pulse_go;
    wait_halt("t4b_halt", 0);
    chk("t4b_err", err, 0);
    drain("t4b_drain");
    addr_on = 1'b0;
    // T5: one call too many
    clear_ram;
    for (int k = 0; k <= D; k++) ram[lvl(k)] = 16'hA000 | 16'(lvl(k + 1));
    pulse_go;
    wait_halt("t5_halt", 0);
`ifdef AVG_STACK_CHECK_EN
    chk("t5_err", err, 1);
    chk("t5_pc", mem_addr, lvl(D) + 13'd1);
`else
    chk("t5_err", err, 0);
    chk("t5_pc", mem_addr, lvl(D + 1) + 13'd1);
`endif
    // T6: abort while fetching the second VCTR word
    clear_ram;
    ram[0] = 16'h1FFF;
    ram[1] = 16'hE001;
    pulse_go;
    tick;
    tick;
    chk("t6_rd1", {mem_rd, mem_addr}, {1'b1, 13'd1});
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t6_abort", {busy, halted, cmd_valid, err, mem_rd}, 0);
    go = 1'b1;
    abort = 1'b1;
    tick;
    go = 1'b0;
    abort = 1'b0;
    chk("t6_prio", {busy, mem_rd}, 0);
    exp_q.push_back(cmdv(2'd0, 13'd1, 13'h1FFF, 4'hE, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0));
    go_lat("t6_lat", 5);
    wait_halt("t6_halt", 0);
    drain("t6_drain");
    // T7: mixed ops, JMP, random backpressure
    clear_ram;
    ram[0] = 16'h5F23;
    ram[1] = 16'h75A5;
    ram[2] = 16'h8000;
    ram[3] = 16'hE100;
    ram[16'h100] = 16'h0ABC;
    ram[16'h101] = 16'h4F00;
    exp_q.push_back(cmdv(2'd0, 13'd6, 13'h1FFE, 4'd0, 1'b1, 1'b0, 3'd0, 8'd0, 3'd0));
    exp_q.push_back(cmdv(2'd2, 13'd0, 13'd0, 4'd0, 1'b0, 1'b0, 3'd0, 8'hA5, 3'd5));
    exp_q.push_back(cmdv(2'd3, 13'd0, 13'd0, 4'd0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0));
    exp_q.push_back(cmdv(2'd0, 13'h0F00, 13'h0ABC, 4'd4, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0));
    pulse_go;
    wait_halt("t7_halt", 1);
    chk("t7_pc", mem_addr, 13'h103);
    drain("t7_drain");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
